// File: rtl/timer_sched_pkg.sv
// Shared register map for the timer scheduler: register offsets within a
// channel window and the bit positions inside CTRL and STATUS.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_TERM   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_HALT  = 1;
  localparam int CTRL_MODE  = 2;
  localparam int CTRL_IE    = 3;

  localparam int STAT_RUN   = 0;
  localparam int STAT_PEND  = 1;

endpackage

// File: rtl/timer_sched_chan.sv
// One timer channel: free-running up-counter compared against a terminal
// count, with one-shot / continuous mode and a sticky pending flag.
module timer_chan #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          halt,
  input  logic          cfg_we,
  input  logic          cfg_mode,
  input  logic          cfg_ie,
  input  logic          term_we,
  input  logic [CW-1:0] term_wdata,
  input  logic          clr_pend,
  output logic [CW-1:0] count,
  output logic [CW-1:0] term,
  output logic          running,
  output logic          pending,
  output logic          mode,
  output logic          ie
);

  logic tc_hit;

  // A halt in the same cycle as a terminal match suppresses the event.
  assign tc_hit = running && !halt && (count == term);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      term    <= '0;
      running <= 1'b0;
      pending <= 1'b0;
      mode    <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (cfg_we) begin
        mode <= cfg_mode;
        ie   <= cfg_ie;
      end
      if (term_we) begin
        term <= term_wdata;
      end
      if (halt) begin
        running <= 1'b0;
        count   <= '0;
      end else if (running) begin
        if (count == term) begin
          if (mode) begin
            count <= '0;
          end else begin
            running <= 1'b0;
          end
        end else begin
          count <= count + CW'(1);
        end
      end else if (start) begin
        running <= 1'b1;
        count   <= '0;
      end
      // New terminal event beats a software clear landing in the same cycle.
      if (tc_hit) begin
        pending <= 1'b1;
      end else if (clr_pend) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Multi-channel timer controller: bus handshake and decode, per-channel
// timers, read mux and fixed-priority interrupt encoder (channel 0 highest).
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        irq,
  output logic [1:0]  irq_id
);

  logic          rsp_valid_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          accept;
  logic [1:0]    acc_chan;
  reg_sel_e      acc_reg;
  logic [31:0]   rd_mux;
  logic [31:0]   rd_word [NCH];
  logic [CW-1:0] count_w [NCH];
  logic [CW-1:0] term_w  [NCH];
  logic [NCH-1:0] running_w, pending_w, mode_w, ie_w;
  logic          unused_addr_bits;

  assign req_ready        = !rsp_valid_reg;
  assign rsp_valid        = rsp_valid_reg;
  assign rsp_rdata        = rsp_rdata_reg;
  assign accept           = req_valid && !rsp_valid_reg;
  assign acc_chan         = req_addr[5:4];
  assign acc_reg          = reg_sel_e'(req_addr[3:2]);
  assign unused_addr_bits = ^req_addr[1:0];

  // Channels at or above NCH have no instance, so writes vanish and reads OR in nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic        wr_hit;
      logic        cfg_we;
      logic [31:0] rd_local;

      assign wr_hit = accept && req_we && (acc_chan == 2'(gi));
      assign cfg_we = wr_hit && (acc_reg == REG_CTRL);

      timer_chan #(.CW(CW)) u_chan (
        .clk        (clk),
        .reset      (reset),
        .start      (cfg_we && req_wdata[CTRL_START]),
        .halt       (cfg_we && req_wdata[CTRL_HALT]),
        .cfg_we     (cfg_we),
        .cfg_mode   (req_wdata[CTRL_MODE]),
        .cfg_ie     (req_wdata[CTRL_IE]),
        .term_we    (wr_hit && (acc_reg == REG_TERM)),
        .term_wdata (req_wdata[CW-1:0]),
        .clr_pend   (wr_hit && (acc_reg == REG_STATUS) && req_wdata[STAT_PEND]),
        .count      (count_w[gi]),
        .term       (term_w[gi]),
        .running    (running_w[gi]),
        .pending    (pending_w[gi]),
        .mode       (mode_w[gi]),
        .ie         (ie_w[gi])
      );

      always_comb begin
        rd_local = '0;
        if (acc_chan == 2'(gi)) begin
          case (acc_reg)
            REG_CTRL: begin
              rd_local[CTRL_IE]   = ie_w[gi];
              rd_local[CTRL_MODE] = mode_w[gi];
            end
            REG_TERM:  rd_local = 32'(term_w[gi]);
            REG_COUNT: rd_local = 32'(count_w[gi]);
            REG_STATUS: begin
              rd_local[STAT_PEND] = pending_w[gi];
              rd_local[STAT_RUN]  = running_w[gi];
            end
            default: rd_local = '0;
          endcase
        end
      end

      assign rd_word[gi] = rd_local;
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_mux = rd_mux | rd_word[i];
    end
  end

  assign irq = |(pending_w & ie_w);

  // Scan from the top so the lowest-numbered active channel is the last write.
  always_comb begin
    irq_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_w[i] && ie_w[i]) begin
        irq_id = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= req_we ? 32'd0 : rd_mux;
    end else if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: table of register accesses, then
// hand-timed sequences for counting, interrupts, priority and response hold.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        irq;
  logic [1:0]  irq_id;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] r_data;
  logic        r_vld;
  logic        r_irq;
  logic [1:0]  r_id;
  int          r_cyc;

  typedef struct {
    logic        we;
    int          ch;
    int          rg;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [15];

  timer_sched #(.NCH(4), .CW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .irq       (irq),
    .irq_id    (irq_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ad(input int ch, input int rg);
    return {2'(ch), 2'(rg), 2'b00};
  endfunction

  // Issue one request from a negedge; capture the response one cycle later.
  task automatic bus_op(input logic we, input logic [5:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    r_data = rsp_rdata;
    r_vld  = rsp_valid;
    r_irq  = irq;
    r_id   = irq_id;
    r_cyc  = cyc;
    $display("txn cyc=%0d we=%0b ch=%0d reg=%0d wdata=0x%0h rdata=0x%0h irq=%0b id=%0d",
             r_cyc, we, a[5:4], a[3:2], d, r_data, r_irq, r_id);
    @(negedge clk);
  endtask

  task automatic wait_irq(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (irq) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at;
    int s0, s1, s2, hold_cyc;
    logic [31:0] hold_exp;

    vt[0]  = '{1'b1, 1, 1, 32'hdeadbeef, 32'h0};
    vt[1]  = '{1'b0, 1, 1, 32'h0,        32'hdeadbeef};
    vt[2]  = '{1'b1, 1, 0, 32'hc,        32'h0};
    vt[3]  = '{1'b0, 1, 0, 32'h0,        32'hc};
    vt[4]  = '{1'b1, 1, 2, 32'h55,       32'h0};
    vt[5]  = '{1'b0, 1, 2, 32'h0,        32'h0};
    vt[6]  = '{1'b0, 1, 3, 32'h0,        32'h0};
    vt[7]  = '{1'b1, 2, 0, 32'h3,        32'h0};
    vt[8]  = '{1'b0, 2, 3, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 2, 2, 32'h0,        32'h0};
    vt[10] = '{1'b1, 1, 0, 32'h0,        32'h0};
    vt[11] = '{1'b0, 1, 0, 32'h0,        32'h0};
    vt[12] = '{1'b0, 0, 1, 32'h0,        32'h0};
    vt[13] = '{1'b1, 3, 3, 32'hffffffff, 32'h0};
    vt[14] = '{1'b0, 3, 3, 32'h0,        32'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_irq_id", 32'(irq_id), 32'd0);

    for (int i = 0; i < 15; i++) begin
      bus_op(vt[i].we, ad(vt[i].ch, vt[i].rg), vt[i].wdata);
      chk($sformatf("tbl%0d_valid", i), 32'(r_vld), 32'd1);
      chk($sformatf("tbl%0d_rdata", i), r_data, vt[i].exp);
    end

    // Channel 0: continuous, term 3.
    bus_op(1'b1, ad(0, 1), 32'd3);
    bus_op(1'b1, ad(0, 0), 32'hd);
    s0 = r_cyc;
    wait_irq(20, at);
    chk("ch0_first_irq_cyc", 32'(at), 32'(s0 + 4));
    chk("ch0_irq_id", 32'(irq_id), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus_op(1'b0, ad(0, 2), 32'd0);
      chk("ch0_count", r_data, 32'((r_cyc - 1 - s0) % 4));
    end
    bus_op(1'b1, ad(0, 0), 32'hd);
    bus_op(1'b0, ad(0, 2), 32'd0);
    chk("ch0_count_restart_ignored", r_data, 32'((r_cyc - 1 - s0) % 4));
    bus_op(1'b0, ad(0, 3), 32'd0);
    chk("ch0_status", r_data, 32'h3);

    // Clear away from a terminal edge, then watch the next re-raise.
    for (int i = 0; i < 8 && ((cyc + 1 - s0) % 4) != 2; i++) @(negedge clk);
    bus_op(1'b1, ad(0, 3), 32'h2);
    chk("ch0_clr_irq", 32'(r_irq), 32'd0);
    wait_irq(20, at);
    chk("ch0_reraise_phase", 32'((at - s0) % 4), 32'd0);

    // Clear landing exactly on a terminal edge: set must win.
    for (int i = 0; i < 8 && ((cyc + 1 - s0) % 4) != 0; i++) @(negedge clk);
    bus_op(1'b1, ad(0, 3), 32'h2);
    bus_op(1'b0, ad(0, 3), 32'd0);
    chk("ch0_clr_vs_set", r_data, 32'h3);

    bus_op(1'b1, ad(0, 0), 32'h2);
    bus_op(1'b1, ad(0, 3), 32'h2);
    chk("ch0_halt_clr_irq", 32'(r_irq), 32'd0);
    bus_op(1'b0, ad(0, 2), 32'd0);
    chk("ch0_halt_count", r_data, 32'd0);

    // Channel 1: one-shot, term 5.
    bus_op(1'b1, ad(1, 1), 32'd5);
    bus_op(1'b1, ad(1, 0), 32'h9);
    s1 = r_cyc;
    wait_irq(30, at);
    chk("ch1_irq_cyc", 32'(at), 32'(s1 + 6));
    chk("ch1_irq_id", 32'(irq_id), 32'd1);
    bus_op(1'b0, ad(1, 2), 32'd0);
    chk("ch1_count_hold", r_data, 32'd5);
    bus_op(1'b0, ad(1, 3), 32'd0);
    chk("ch1_status", r_data, 32'h2);
    bus_op(1'b1, ad(1, 3), 32'h2);
    chk("ch1_clr_irq", 32'(r_irq), 32'd0);

    // Channels 2 and 3: term 0 one-shot, both pending.
    bus_op(1'b1, ad(3, 0), 32'h9);
    bus_op(1'b1, ad(2, 0), 32'h9);
    chk("prio_irq", 32'(irq), 32'd1);
    chk("prio_id_2", 32'(irq_id), 32'd2);
    bus_op(1'b1, ad(2, 3), 32'h2);
    chk("prio_after_clr2_irq", 32'(r_irq), 32'd1);
    chk("prio_id_3", 32'(r_id), 32'd3);
    bus_op(1'b1, ad(3, 3), 32'h2);
    chk("prio_after_clr3_irq", 32'(r_irq), 32'd0);
    chk("prio_after_clr3_id", 32'(r_id), 32'd0);

    // Response hold with a live counter underneath, then reset mid-hold.
    bus_op(1'b1, ad(0, 1), 32'd3);
    bus_op(1'b1, ad(0, 0), 32'hd);
    s2 = r_cyc;
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ad(0, 2);
    @(negedge clk);
    req_valid = 1'b0;
    hold_cyc  = cyc;
    hold_exp  = 32'((hold_cyc - 1 - s2) % 4);
    $display("txn cyc=%0d held COUNT read rdata=0x%0h", hold_cyc, rsp_rdata);
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, hold_exp);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    bus_op(1'b0, ad(0, 2), 32'd0);
    chk("post_rst_count", r_data, 32'd0);
    bus_op(1'b0, ad(0, 1), 32'd0);
    chk("post_rst_term", r_data, 32'd0);
    bus_op(1'b0, ad(0, 3), 32'd0);
    chk("post_rst_status", r_data, 32'd0);
    bus_op(1'b0, ad(0, 0), 32'd0);
    chk("post_rst_ctrl", r_data, 32'd0);
    bus_op(1'b0, ad(1, 1), 32'd0);
    chk("post_rst_ch1_term", r_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
